// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin AXI4-Stream arbiter.
// A grant is held from the first beat through TLAST; TID carries the source.
module axis_rr_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic [ID_WIDTH-1:0]           m_axis_tid,
   input  logic                          m_axis_tready,
   output logic                          busy,
   output logic [ID_WIDTH-1:0]           grant_idx,
   output logic [15:0]                   pkt_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_SRC - 1);

   state_t                state;
   state_t                state_nxt;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   pick;
   logic [NUM_SRC-1:0]    req_rot;
   logic                  found;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  eop;

   // Rotate requests so bit k is source (rr_ptr + k) mod NUM_SRC.
   always_comb begin
      req_rot = NUM_SRC'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr);
      found   = 1'b0;
      pick    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            pick  = ID_WIDTH'((int'(rr_ptr) + k) % NUM_SRC);
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == ID_WIDTH'(i)) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign busy = (state == BUSY);

   always_comb begin
      m_axis_tvalid = busy & sel_valid;
      m_axis_tlast  = busy & sel_last;
      m_axis_tdata  = busy ? sel_data : '0;
      m_axis_tid    = busy ? grant_idx : '0;
      s_axis_tready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         s_axis_tready[i] = busy && (grant_idx == ID_WIDTH'(i))
                            && m_axis_tready;
      end
   end

   assign eop = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (found) state_nxt = BUSY;
         BUSY: if (eop)   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
         pkt_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            grant_idx <= pick;
         end
         // The finishing source drops to lowest priority.
         if (eop) begin
            rr_ptr    <= (grant_idx == LAST_IDX) ? '0
                         : grant_idx + ID_WIDTH'(1);
            pkt_count <= pkt_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: randomized bench for axis_rr_arbiter.
// Sources and sink are modelled per packet; expectations come from queues.
module tb_axis_rr_arbiter;

   localparam int NS    = 4;
   localparam int DW    = 32;
   localparam int IW    = 2;
   localparam int DEPTH = 64;
   localparam int TMAX  = 1024;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic [NS*DW-1:0] s_axis_tdata;
   logic [NS-1:0]    s_axis_tvalid;
   logic [NS-1:0]    s_axis_tlast;
   logic [NS-1:0]    s_axis_tready;
   logic [DW-1:0]    m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tlast;
   logic [IW-1:0]    m_axis_tid;
   logic             m_axis_tready;
   logic             busy;
   logic [IW-1:0]    grant_idx;
   logic [15:0]      pkt_count;

   int total = 0;
   int bad   = 0;

   always #5 aclk = ~aclk;

   axis_rr_arbiter #(
      .NUM_SRC    (NS),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .grant_idx     (grant_idx),
      .pkt_count     (pkt_count)
   );

   // Per-source beat queues and valid gating.
   logic [DW-1:0] sdat [NS][DEPTH];
   logic          slst [NS][DEPTH];
   int            shead [NS];
   int            slen [NS];
   int            stall [NS];
   int            stall_at [NS];
   int            stall_len [NS];
   logic          vcur [NS];
   int            vprob;
   int            rdy_per;
   int            rdy_low;
   int            cyc;

   // Per-cycle trace of the sink side.
   logic          t_busy [TMAX];
   logic          t_mv [TMAX];
   logic          t_mr [TMAX];
   logic          t_hs [TMAX];
   logic          t_last [TMAX];
   logic [IW-1:0] t_tid [TMAX];
   logic [IW-1:0] t_grant [TMAX];
   logic [DW-1:0] t_data [TMAX];
   logic [NS-1:0] t_sr [TMAX];
   int            tn;

   task automatic clear_src();
      for (int i = 0; i < NS; i++) begin
         shead[i]     = 0;
         slen[i]      = 0;
         stall[i]     = 0;
         stall_at[i]  = -1;
         stall_len[i] = 0;
         vcur[i]      = 1'b0;
      end
      tn = 0;
   endtask

   task automatic add_beat(input int s, input logic [DW-1:0] d,
                           input logic l);
      sdat[s][slen[s]] = d;
      slst[s][slen[s]] = l;
      slen[s]++;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn       = 1'b0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b1;
      rdy_per       = 0;
      rdy_low       = 0;
      vprob         = 100;
      clear_src();
      @(negedge aclk);
      aresetn = 1'b1;
      cyc     = 0;
   endtask

   // One cycle: drive at negedge, sample 1ns later, retire handshakes.
   task automatic step();
      @(negedge aclk);
      if (rdy_per > 0) m_axis_tready = (cyc % rdy_per) >= rdy_low;
      for (int i = 0; i < NS; i++) begin
         if (stall[i] > 0) stall[i]--;
         else if (!vcur[i] && shead[i] < slen[i]
                  && $urandom_range(99) < vprob) vcur[i] = 1'b1;
         s_axis_tvalid[i] = vcur[i];
         if (shead[i] < slen[i]) begin
            s_axis_tdata[i*DW +: DW] = sdat[i][shead[i]];
            s_axis_tlast[i]          = slst[i][shead[i]];
         end else begin
            s_axis_tdata[i*DW +: DW] = '0;
            s_axis_tlast[i]          = 1'b0;
         end
      end
      cyc++;
      #1;
      if (tn < TMAX) begin
         t_busy[tn]  = busy;
         t_mv[tn]    = m_axis_tvalid;
         t_mr[tn]    = m_axis_tready;
         t_hs[tn]    = m_axis_tvalid && m_axis_tready;
         t_last[tn]  = m_axis_tlast;
         t_tid[tn]   = m_axis_tid;
         t_grant[tn] = grant_idx;
         t_data[tn]  = m_axis_tdata;
         t_sr[tn]    = s_axis_tready;
         tn++;
      end
      for (int i = 0; i < NS; i++) begin
         if (s_axis_tvalid[i] && s_axis_tready[i]) begin
            shead[i]++;
            vcur[i] = 1'b0;
            if (shead[i] == stall_at[i]) stall[i] = stall_len[i];
         end
      end
   endtask

   task automatic test_reset();
      aresetn       = 1'b0;
      s_axis_tvalid = '1;
      s_axis_tlast  = '0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b1;
      clear_src();
      repeat (2) @(negedge aclk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      total++;
      if (m_axis_tvalid !== 1'b0) begin
         bad++; $display("FAIL reset_mvalid: got %b want 0", m_axis_tvalid);
      end
      total++;
      if (s_axis_tready !== 4'h0) begin
         bad++; $display("FAIL reset_sready: got %h want 0", s_axis_tready);
      end
      total++;
      if (m_axis_tid !== 2'd0 || grant_idx !== 2'd0) begin
         bad++;
         $display("FAIL reset_ids: tid %0d grant %0d want 0 0",
                  m_axis_tid, grant_idx);
      end
      total++;
      if (pkt_count !== 16'h0) begin
         bad++; $display("FAIL reset_count: got %h want 0", pkt_count);
      end
      aresetn = 1'b1;
      @(negedge aclk);
      #1;
      total++;
      if (busy !== 1'b1 || m_axis_tid !== 2'd0 || s_axis_tready !== 4'b0001)
      begin
         bad++;
         $display("FAIL reset_first_grant: busy %b tid %0d rdy %b want 1 0 0001",
                  busy, m_axis_tid, s_axis_tready);
      end
   endtask

   task automatic test_single();
      int nb;
      int bcyc;
      do_reset();
      for (int b = 0; b < 4; b++) add_beat(0, DW'(b + 1), b == 3);
      repeat (8) step();
      nb   = 0;
      bcyc = 0;
      for (int t = 0; t < tn; t++) begin
         if (t_busy[t]) bcyc++;
         if (t_hs[t]) begin
            total++;
            if (t_data[t] !== DW'(nb + 1) || t_tid[t] !== 2'd0
                || t_last[t] !== (nb == 3)) begin
               bad++;
               $display("FAIL single_beat%0d: data %h tid %0d last %b want %h 0 %b",
                        nb, t_data[t], t_tid[t], t_last[t], nb + 1, nb == 3);
            end
            nb++;
         end
      end
      total++;
      if (nb != 4) begin
         bad++; $display("FAIL single_nbeats: got %0d want 4", nb);
      end
      total++;
      if (bcyc != 4) begin
         bad++; $display("FAIL single_busy_cycles: got %0d want 4", bcyc);
      end
      total++;
      if (pkt_count !== 16'd1) begin
         bad++; $display("FAIL single_count: got %0d want 1", pkt_count);
      end
   endtask

   task automatic test_fairness();
      int            exp_tid [8];
      int            left [NS];
      int            ocnt [NS];
      int            ptr;
      int            j;
      int            e;
      int            np;
      int            steps;
      logic          got;
      logic          first;
      logic [DW-1:0] d;
      do_reset();
      for (int i = 0; i < NS; i++) begin
         for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 2; b++) begin
               d = DW'((p << 24) | (b << 16) | (32'hA0 + 32'h10 * i + i));
               add_beat(i, d, b == 1);
            end
         end
         left[i] = 3;
         ocnt[i] = 0;
      end
      // Round robin over sources that still have packets queued.
      ptr = 0;
      for (int n = 0; n < 8; n++) begin
         got = 1'b0;
         for (int k = 0; k < NS; k++) begin
            j = (ptr + k) % NS;
            if (!got && left[j] > 0) begin
               exp_tid[n] = j;
               left[j]--;
               ptr = (j + 1) % NS;
               got = 1'b1;
            end
         end
      end
      np    = 0;
      steps = 0;
      while (np < 8 && steps < 200) begin
         step();
         steps++;
         if (t_hs[tn-1] && t_last[tn-1]) np++;
      end
      step();
      total++;
      if (np != 8) begin
         bad++; $display("FAIL fair_timeout: got %0d packets want 8", np);
      end
      np    = 0;
      first = 1'b1;
      e     = 0;
      for (int t = 0; t < tn; t++) begin
         if (t_hs[t] && np < 8) begin
            if (first) e = exp_tid[np];
            first = 1'b0;
            total++;
            if (t_tid[t] !== IW'(e) || t_data[t] !== sdat[e][ocnt[e]]) begin
               bad++;
               $display("FAIL fair_beat pkt%0d: tid %0d data %h want %0d %h",
                        np, t_tid[t], t_data[t], e, sdat[e][ocnt[e]]);
            end
            ocnt[e]++;
            if (t_last[t]) begin
               np++;
               first = 1'b1;
               if (t + 1 < tn) begin
                  total++;
                  if (t_busy[t+1] !== 1'b0 || t_mv[t+1] !== 1'b0) begin
                     bad++;
                     $display("FAIL fair_gap pkt%0d: busy %b valid %b want 0 0",
                              np, t_busy[t+1], t_mv[t+1]);
                  end
               end
               if (np < 8 && t + 2 < tn) begin
                  total++;
                  if (t_busy[t+2] !== 1'b1) begin
                     bad++;
                     $display("FAIL fair_regrant pkt%0d: busy %b want 1",
                              np, t_busy[t+2]);
                  end
               end
            end
         end
      end
      total++;
      if (pkt_count !== 16'd8) begin
         bad++; $display("FAIL fair_count: got %0d want 8", pkt_count);
      end
   endtask

   task automatic test_backpressure();
      int   o [NS];
      int   s;
      int   steps;
      int   nhs;
      int   leak;
      logic l;
      do_reset();
      rdy_per = 8;
      rdy_low = 2;
      vprob   = 60;
      for (int q = 0; q < 2; q++) begin
         s = 1 + 2 * q;
         for (int b = 0; b < 16; b++) begin
            l = (b == 15) || ($urandom_range(3) == 0);
            add_beat(s, $urandom, l);
         end
      end
      steps = 0;
      while ((shead[1] < 16 || shead[3] < 16) && steps < 400) begin
         step();
         steps++;
      end
      total++;
      if (shead[1] < 16 || shead[3] < 16) begin
         bad++;
         $display("FAIL bp_timeout: src1 %0d src3 %0d want 16 16",
                  shead[1], shead[3]);
      end
      for (int i = 0; i < NS; i++) o[i] = 0;
      nhs  = 0;
      leak = 0;
      for (int t = 0; t < tn; t++) begin
         if ((t_sr[t] & 4'b0101) != 0 || $countones(t_sr[t]) > 1
             || (t_sr[t] != 0 && !t_mr[t])) leak++;
         if (t_hs[t]) begin
            nhs++;
            s = int'(t_tid[t]);
            total++;
            if ((s != 1 && s != 3) || o[s] >= 16) begin
               bad++;
               $display("FAIL bp_tid: got %0d want 1 or 3 with beats left", s);
            end else begin
               total++;
               if (t_data[t] !== sdat[s][o[s]] || t_last[t] !== slst[s][o[s]])
               begin
                  bad++;
                  $display("FAIL bp_beat src%0d #%0d: %h/%b want %h/%b",
                           s, o[s], t_data[t], t_last[t],
                           sdat[s][o[s]], slst[s][o[s]]);
               end
               o[s]++;
            end
         end
      end
      total++;
      if (o[1] != 16 || o[3] != 16 || nhs != shead[1] + shead[3]) begin
         bad++;
         $display("FAIL bp_counts: out %0d/%0d sink %0d src %0d want 16/16",
                  o[1], o[3], nhs, shead[1] + shead[3]);
      end
      total++;
      if (leak != 0) begin
         bad++; $display("FAIL bp_tready_leak: %0d cycles want 0", leak);
      end
   endtask

   task automatic test_stall();
      int steps;
      int last2;
      int first0;
      int gap;
      int gbad;
      int o2;
      do_reset();
      for (int b = 0; b < 4; b++) add_beat(2, 32'h2000_0000 + DW'(b), b == 3);
      for (int b = 0; b < 2; b++) add_beat(0, 32'h0000_0100 + DW'(b), b == 1);
      stall[0]     = 3;
      stall_at[2]  = 2;
      stall_len[2] = 5;
      steps = 0;
      while ((shead[0] < 2 || shead[2] < 4) && steps < 100) begin
         step();
         steps++;
      end
      total++;
      if (shead[0] < 2 || shead[2] < 4) begin
         bad++;
         $display("FAIL stall_timeout: src0 %0d src2 %0d want 2 4",
                  shead[0], shead[2]);
      end
      last2  = -1;
      first0 = -1;
      gap    = 0;
      gbad   = 0;
      o2     = 0;
      for (int t = 0; t < tn; t++) begin
         if (last2 < 0 && t_busy[t]) begin
            if (t_grant[t] !== 2'd2) gbad++;
            if (!t_mv[t]) gap++;
         end
         if (t_hs[t] && t_tid[t] == 2'd2) begin
            total++;
            if (o2 >= 4 || t_data[t] !== sdat[2][o2]) begin
               bad++;
               $display("FAIL stall_src2_beat%0d: got %h", o2, t_data[t]);
            end
            o2++;
            if (t_last[t]) last2 = t;
         end
         if (t_hs[t] && t_tid[t] == 2'd0 && first0 < 0) first0 = t;
      end
      total++;
      if (gbad != 0) begin
         bad++; $display("FAIL stall_grant: %0d cycles off source 2", gbad);
      end
      total++;
      if (gap != 5) begin
         bad++; $display("FAIL stall_gap: %0d idle beats want 5", gap);
      end
      total++;
      if (last2 < 0 || first0 != last2 + 2) begin
         bad++;
         $display("FAIL stall_order: src0 at %0d src2 last at %0d want last+2",
                  first0, last2);
      end
   endtask

   task automatic test_reset_mid();
      int steps;
      int ptr;
      int e;
      logic got;
      do_reset();
      add_beat(2, 32'h0000_2222, 1'b1);
      steps = 0;
      while (shead[2] < 1 && steps < 20) begin
         step();
         steps++;
      end
      step();
      for (int b = 0; b < 4; b++) add_beat(1, 32'h1111_0000 + DW'(b), b == 3);
      steps = 0;
      while (shead[1] < 1 && steps < 20) begin
         step();
         steps++;
      end
      total++;
      if (shead[1] != 1 || pkt_count !== 16'd1) begin
         bad++;
         $display("FAIL rmid_setup: beats %0d count %0d want 1 1",
                  shead[1], pkt_count);
      end
      step();
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      clear_src();
      add_beat(1, 32'h1111_00AA, 1'b1);
      add_beat(3, 32'h3333_00BB, 1'b1);
      step();
      total++;
      if (busy !== 1'b0 || pkt_count !== 16'd0 || s_axis_tready !== 4'h0
          || m_axis_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL rmid_after_reset: busy %b count %0d rdy %h valid %b",
                  busy, pkt_count, s_axis_tready, m_axis_tvalid);
      end
      // After reset the search restarts at source 0.
      ptr = 0;
      e   = 0;
      got = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (!got && ((ptr + k) % NS == 1 || (ptr + k) % NS == 3)) begin
            e   = (ptr + k) % NS;
            got = 1'b1;
         end
      end
      step();
      total++;
      if (busy !== 1'b1 || m_axis_tid !== IW'(e)
          || m_axis_tdata !== sdat[e][0]) begin
         bad++;
         $display("FAIL rmid_regrant: busy %b tid %0d data %h want 1 %0d %h",
                  busy, m_axis_tid, m_axis_tdata, e, sdat[e][0]);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp;
      int          steps;
      do_reset();
      @(negedge aclk);
      force dut.pkt_count = 16'hFFFE;
      #1;
      release dut.pkt_count;
      exp = 16'hFFFE;
      for (int n = 0; n < 2; n++) begin
         add_beat(n, 32'hCAFE_0000 + DW'(n), 1'b1);
         steps = 0;
         while (shead[n] < 1 && steps < 20) begin
            step();
            steps++;
         end
         step();
         exp = exp + 16'd1;
         total++;
         if (pkt_count !== exp) begin
            bad++;
            $display("FAIL wrap_count%0d: got %h want %h", n, pkt_count, exp);
         end
      end
   endtask

   initial begin
      tn      = 0;
      cyc     = 0;
      vprob   = 100;
      rdy_per = 0;
      rdy_low = 0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
